// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, data width, idle line level
// and the per-frame bit-order helper.
package uart_pkg;

  localparam int   DATA_W     = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Data bit sent in slot idx of the data field, for either bit order.
  function automatic logic frame_bit(input logic [DATA_W-1:0] b,
                                     input logic [2:0]        idx,
                                     input logic              big);
    return big ? b[3'd7 - idx] : b[idx];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter: active-low write/read strobes,
// show-ahead read data, registered full/empty flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              n_we_i,
  input  logic              n_re_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              wr_en, rd_en;

  // Strobes are qualified by the registered flags, so a write while full is
  // dropped even when a pop happens in the same cycle.
  assign wr_en = !n_we_i && !full_q;
  assign rd_en = !n_re_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit core: FIFO-buffered bytes framed as start, 8 data, optional parity
// (built only with UART_TX_PARITY_EN defined) and stop bit, one bit per baud tick.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic              n_we_i,
  output logic              p_full_o,
  output logic              p_empty_o,
  input  logic              p_BaudSig_i,
  input  logic              p_ParityEnable_i,
  input  logic              ParityMethod_i,
  input  logic              p_BigEnd_i,
  output logic              Tx_o,
  output logic              p_busy_o,
  output logic              p_TxDone_o,
  output tx_state_e         dbg_state_o
);

  // Host handshake: each clk with n_we_i low offers data_i; it is taken when
  // p_full_o is low in that same cycle, otherwise silently dropped.
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              big_q, big_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              pop;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
`else
  logic unused_parity_ctrl;
  assign unused_parity_ctrl = p_ParityEnable_i ^ ParityMethod_i;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .n_we_i  (n_we_i),
    .n_re_i  (!pop),
    .data_o  (fifo_data),
    .full_o  (p_full_o),
    .empty_o (fifo_empty)
  );

  // tx_d is the level of the bit selected by this tick, so the line is registered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    big_d   = big_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
`endif
    if (p_BaudSig_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end
        ST_START: begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
          tx_d    = frame_bit(shreg_q, 3'd0, big_q);
        end
        ST_DATA: begin
          if (cnt_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = (^shreg_q) ^ par_odd_q;
            end
`endif
          end else begin
            cnt_d = cnt_q + 3'd1;
            tx_d  = frame_bit(shreg_q, cnt_q + 3'd1, big_q);
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = IDLE_LEVEL;
        end
        ST_STOP: begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = IDLE_LEVEL;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = IDLE_LEVEL;
        end
      endcase
    end
    // Frame controls are sampled only when a byte is popped.
    if (pop) begin
      shreg_d = fifo_data;
      big_d   = p_BigEnd_i;
`ifdef UART_TX_PARITY_EN
      par_en_d  = p_ParityEnable_i;
      par_odd_d = ParityMethod_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      big_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      big_q   <= big_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
`endif
    end
  end

  assign Tx_o        = tx_q;
  assign p_busy_o    = (state_q != ST_IDLE);
  assign p_TxDone_o  = done_q;
  assign p_empty_o   = fifo_empty;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: frame-level reference model compared every cycle,
// directed scenarios with literal bit patterns, then randomized traffic.
module tb_uart_tx_core;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data_i = 8'h00;
  logic       n_we_i = 1'b1;
  logic       tick = 1'b0;
  logic       pe = 1'b0, pm = 1'b0, be = 1'b0;
  logic       Tx_o, p_busy_o, p_TxDone_o, p_full_o, p_empty_o;
  tx_state_e  dbg_state;

  uart_tx_core #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .n_we_i           (n_we_i),
    .p_full_o         (p_full_o),
    .p_empty_o        (p_empty_o),
    .p_BaudSig_i      (tick),
    .p_ParityEnable_i (pe),
    .ParityMethod_i   (pm),
    .p_BigEnd_i       (be),
    .Tx_o             (Tx_o),
    .p_busy_o         (p_busy_o),
    .p_TxDone_o       (p_TxDone_o),
    .dbg_state_o      (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes waiting (exp_q), plus the full bit list of the frame on the line.
  logic [7:0] exp_q[$];
  logic       frame_q[$];
  int         pos = 0;
  bit         active = 0;
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  logic       exp_full = 1'b0, exp_empty = 1'b1;
  bit         tick_seen = 0;
  int         tick_total = 0;

  function automatic void build_frame(input logic [7:0] b);
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) frame_q.push_back(be ? b[7-i] : b[i]);
`ifdef UART_TX_PARITY_EN
    if (pe) frame_q.push_back((^b) ^ pm);
`endif
    frame_q.push_back(1'b1);
  endfunction

  task automatic model_step();
    int  sz;
    bit  was_full, was_empty, do_pop;
    if (!rst) begin
      exp_q.delete();
      frame_q.delete();
      active = 0; pos = 0; tick_seen = 0;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      exp_full = 1'b0; exp_empty = 1'b1;
      return;
    end
    sz        = exp_q.size();
    was_full  = (sz == DEPTH);
    was_empty = (sz == 0);
    do_pop    = 0;
    exp_done  = 1'b0;
    tick_seen = tick;
    if (tick) begin
      tick_total++;
      if (!active) begin
        if (!was_empty) do_pop = 1;
      end else begin
        pos++;
        if (pos == frame_q.size()) begin
          exp_done = 1'b1;
          active   = 0;
          exp_tx   = 1'b1;
          if (!was_empty) do_pop = 1;
        end else begin
          exp_tx = frame_q[pos];
        end
      end
      if (do_pop) begin
        build_frame(exp_q.pop_front());
        active = 1;
        pos    = 0;
        exp_tx = frame_q[0];
      end
    end
    if (!n_we_i && !was_full) exp_q.push_back(data_i);
    exp_busy  = active;
    exp_full  = (exp_q.size() == DEPTH);
    exp_empty = (exp_q.size() == 0);
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // ---------------- compare / capture ----------------
  logic cap_q[$];
  int   done_cnt = 0;

  initial forever begin
    @(negedge clk);
    check("tx", Tx_o, exp_tx);
    check("busy", p_busy_o, exp_busy);
    check("done", p_TxDone_o, exp_done);
    check("full", p_full_o, exp_full);
    check("empty", p_empty_o, exp_empty);
    if (tick_seen) cap_q.push_back(Tx_o);
    if (p_TxDone_o) done_cnt++;
  end

  // ---------------- tick generator ----------------
  int tick_mode = 0;   // 0 off, 1 periodic, 2 random
  int tick_per  = 16;
  int tcnt      = 0;

  initial forever begin
    @(negedge clk);
    case (tick_mode)
      1: begin
        tcnt++;
        tick = (tcnt % tick_per == 0);
      end
      2: tick = ($urandom_range(0, 3) == 0);
      default: tick = 1'b0;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b);
    data_i = b;
    n_we_i = 1'b0;
    @(negedge clk);
    n_we_i = 1'b1;
  endtask

  task automatic set_ctrl(input logic p, input logic m, input logic b);
    pe = p; pm = m; be = b;
  endtask

  task automatic start_ticks(input int per);
    tcnt = 0;
    tick_per = per;
    tick_mode = 1;
  endtask

  task automatic start_capture();
    cap_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_ticks(input int n);
    int target, guard;
    target = tick_total + n;
    guard  = 0;
    while (tick_total < target && guard < n * 64 + 100) begin
      @(negedge clk);
      guard++;
    end
    check("tick_wait", 32'(tick_total >= target), 32'd1);
  endtask

  task automatic wait_drained(input int limit);
    int guard;
    guard = 0;
    while ((p_busy_o || !p_empty_o) && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    check("drain_wait", 32'(guard < limit), 32'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    logic [0:9] e_a5;
    logic [7:0] last_b;
    int         zeros;
    e_a5 = 10'b0101001011;

    repeat (3) @(negedge clk);
    check("rst_tx", Tx_o, 1'b1);
    check("rst_busy", p_busy_o, 1'b0);
    check("rst_done", p_TxDone_o, 1'b0);
    check("rst_empty", p_empty_o, 1'b1);
    check("rst_full", p_full_o, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, LSB first, no parity
    set_ctrl(0, 0, 0);
    start_capture();
    write_byte(8'hA5);
    start_ticks(16);
    run_ticks(11);
    tick_mode = 0;
    check("a5_len", 32'(cap_q.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) check($sformatf("a5_bit%0d", i), cap_q[i], e_a5[i]);
    check("a5_done_cnt", done_cnt, 1);
    check("a5_busy_after", p_busy_o, 1'b0);

    // 0x03 even then odd parity; without the parity build slot 9 is the stop bit
    set_ctrl(1, 0, 0);
    start_capture();
    write_byte(8'h03);
    start_ticks(16);
    run_ticks(12);
    tick_mode = 0;
`ifdef UART_TX_PARITY_EN
    check("par_even", cap_q[9], 1'b0);
    check("par_even_stop", cap_q[10], 1'b1);
`else
    check("par_even_off", cap_q[9], 1'b1);
`endif
    set_ctrl(1, 1, 0);
    start_capture();
    write_byte(8'h03);
    start_ticks(16);
    run_ticks(12);
    tick_mode = 0;
    check("par_odd", cap_q[9], 1'b1);
    check("par_done_cnt", done_cnt, 1);

    // 0x80 MSB first
    set_ctrl(0, 0, 1);
    start_capture();
    write_byte(8'h80);
    start_ticks(16);
    run_ticks(11);
    tick_mode = 0;
    check("big_d0", cap_q[1], 1'b1);
    for (int i = 2; i <= 8; i++) check($sformatf("big_d%0d", i - 1), cap_q[i], 1'b0);

    // back-to-back frames
    set_ctrl(0, 0, 0);
    start_capture();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    start_ticks(16);
    run_ticks(31);
    tick_mode = 0;
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_start0", cap_q[0], 1'b0);
    check("b2b_start1", cap_q[10], 1'b0);
    check("b2b_start2", cap_q[20], 1'b0);
    check("b2b_stop2", cap_q[29], 1'b1);
    check("b2b_d0_11", cap_q[1], 1'b1);
    check("b2b_d1_22", cap_q[12], 1'b1);
    check("b2b_idle", cap_q[30], 1'b1);

    // fill past DEPTH with no ticks
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'(i * 7 + 1));
      if (i == DEPTH - 2) check("fill_not_full", p_full_o, 1'b0);
    end
    check("fill_full", p_full_o, 1'b1);
    check("fill_not_empty", p_empty_o, 1'b0);
    write_byte(8'hEE);
    check("fill_still_full", p_full_o, 1'b1);
    start_capture();
    start_ticks(4);
    run_ticks(DEPTH * 10 + 2);
    tick_mode = 0;
    check("fill_done_cnt", done_cnt, DEPTH);
    check("fill_empty", p_empty_o, 1'b1);
    for (int i = 0; i < 8; i++) last_b[i] = cap_q[(DEPTH - 1) * 10 + 1 + i];
    check("fill_last_byte", last_b, 8'((DEPTH - 1) * 7 + 1));

    // randomized traffic: heavy writes, then sparse writes
    tick_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      pe = 1'($urandom_range(0, 1));
      pm = 1'($urandom_range(0, 1));
      be = 1'($urandom_range(0, 1));
      data_i = 8'($urandom);
      if (c < 2000) n_we_i = ($urandom_range(0, 5) != 0);
      else          n_we_i = ($urandom_range(0, 59) != 0);
      @(negedge clk);
    end
    n_we_i = 1'b1;
    wait_drained(4000);
    tick_mode = 0;
    repeat (2) @(negedge clk);

    // reset in the middle of a data field
    set_ctrl(0, 0, 0);
    write_byte(8'h5A);
    write_byte(8'h3C);
    write_byte(8'hC3);
    start_ticks(8);
    run_ticks(3);
    check("pre_rst_busy", p_busy_o, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_tx", Tx_o, 1'b1);
    check("arst_busy", p_busy_o, 1'b0);
    check("arst_empty", p_empty_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    start_capture();
    run_ticks(25);
    tick_mode = 0;
    zeros = 0;
    foreach (cap_q[i]) if (cap_q[i] !== 1'b1) zeros++;
    check("post_rst_line_idle", zeros, 0);
    check("post_rst_done_cnt", done_cnt, 0);
    check("post_rst_empty", p_empty_o, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
